// File: rtl/status_flags_if.sv
// Bundle of ALU-result inputs and flag outputs between an ALU and status_flags_unit.
// valid is a one-cycle qualifier with no ready: the unit accepts every cycle valid=1 unconditionally.
interface status_flags_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             valid;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             borrow;
    logic             mult_ovf;
    logic             div_error;
    logic [2:0]       op;
    logic             sticky_clr;
    logic             irq_ack;

    logic             overflow;
    logic             zero;
    logic             negative;
    logic             error;
    logic             s_overflow;
    logic             s_error;
    logic [CNT_W-1:0] ovf_count;
    logic             irq;
    logic             flags_valid;
    logic             fsm_state;   // debug view of the interrupt FSM (1 = ALERT)

    modport master (
        output valid, result, cout, borrow, mult_ovf, div_error, op, sticky_clr, irq_ack,
        input  overflow, zero, negative, error, s_overflow, s_error, ovf_count, irq,
               flags_valid, fsm_state
    );

    modport slave (
        input  valid, result, cout, borrow, mult_ovf, div_error, op, sticky_clr, irq_ack,
        output overflow, zero, negative, error, s_overflow, s_error, ovf_count, irq,
               flags_valid, fsm_state
    );
endinterface

// File: rtl/status_flags_unit.sv
// Registers ALU status flags, keeps sticky flags plus a saturating overflow counter,
// and raises a level interrupt on overflow/error until acknowledged.
module status_flags_unit #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    status_flags_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, ALERT = 1'b1} irq_state_t;

    localparam logic [2:0]       OP_ADD  = 3'b000;
    localparam logic [2:0]       OP_SUB  = 3'b001;
    localparam logic [2:0]       OP_MUL  = 3'b101;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             raw_ovf, raw_zero, raw_neg, raw_err;
    logic             ev_ovf, ev_err, ev_any;
    logic             overflow_q, zero_q, negative_q, error_q;
    logic             s_overflow_q, s_error_q, flags_valid_q;
    logic [CNT_W-1:0] ovf_count_q;
    irq_state_t       state_q, state_d;

    always_comb begin
        raw_ovf  = ((bus.op == OP_ADD) && bus.cout)   ||
                   ((bus.op == OP_SUB) && bus.borrow) ||
                   ((bus.op == OP_MUL) && bus.mult_ovf);
        raw_zero = (bus.result == '0);
        raw_neg  = bus.result[WIDTH-1];
        raw_err  = bus.div_error;
        ev_ovf   = bus.valid && raw_ovf;
        ev_err   = bus.valid && raw_err;
        ev_any   = ev_ovf || ev_err;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q    <= 1'b0;
            zero_q        <= 1'b0;
            negative_q    <= 1'b0;
            error_q       <= 1'b0;
            flags_valid_q <= 1'b0;
        end else begin
            flags_valid_q <= bus.valid;
            if (bus.valid) begin
                overflow_q <= raw_ovf;
                zero_q     <= raw_zero;
                negative_q <= raw_neg;
                error_q    <= raw_err;
            end
        end
    end

    // A clear drops the old contents but still records an event arriving with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_overflow_q <= 1'b0;
            s_error_q    <= 1'b0;
            ovf_count_q  <= '0;
        end else if (bus.sticky_clr) begin
            s_overflow_q <= ev_ovf;
            s_error_q    <= ev_err;
            ovf_count_q  <= ev_ovf ? CNT_W'(1) : '0;
        end else begin
            if (ev_ovf) s_overflow_q <= 1'b1;
            if (ev_err) s_error_q    <= 1'b1;
            if (ev_ovf && (ovf_count_q != CNT_MAX))
                ovf_count_q <= ovf_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (ev_any) state_d = ALERT;
            ALERT:   if (bus.irq_ack && !ev_any) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.overflow    = overflow_q;
    assign bus.zero        = zero_q;
    assign bus.negative    = negative_q;
    assign bus.error       = error_q;
    assign bus.s_overflow  = s_overflow_q;
    assign bus.s_error     = s_error_q;
    assign bus.ovf_count   = ovf_count_q;
    assign bus.flags_valid = flags_valid_q;
    assign bus.irq         = (state_q == ALERT);
    assign bus.fsm_state   = state_q;
endmodule

// File: tb/tb_status_flags_unit.sv
// Self-checking bench for status_flags_unit: directed scenarios plus random traffic
// against a behavioural flag model; a 16-bit instance covers the wide-result cases.
module tb_status_flags_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  status_flags_if #(.WIDTH(8), .CNT_W(4)) b8 ();
  status_flags_if #(.WIDTH(16), .CNT_W(4)) b16 ();

  status_flags_unit #(.WIDTH(8), .CNT_W(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  status_flags_unit #(.WIDTH(16), .CNT_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

  // behavioural model of the 8-bit instance
  bit m_ovf, m_zero, m_neg, m_err, m_sovf, m_serr, m_fv, m_irq;
  int m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit ev_o, ev_e;
    if (!rst_n) begin
      {m_ovf, m_zero, m_neg, m_err, m_sovf, m_serr, m_fv, m_irq} = '0;
      m_cnt = 0;
    end else begin
      ev_o = b8.valid && ((b8.op == 3'd0 && b8.cout) || (b8.op == 3'd1 && b8.borrow) ||
                          (b8.op == 3'd5 && b8.mult_ovf));
      ev_e = b8.valid && b8.div_error;
      m_fv = b8.valid;
      if (b8.valid) begin
        m_ovf  = ev_o;
        m_zero = (b8.result == 8'd0);
        m_neg  = (b8.result >= 8'd128);
        m_err  = b8.div_error;
      end
      if (b8.sticky_clr) begin
        m_sovf = ev_o;
        m_serr = ev_e;
        m_cnt  = ev_o ? 1 : 0;
      end else begin
        m_sovf = m_sovf | ev_o;
        m_serr = m_serr | ev_e;
        m_cnt  = (m_cnt + int'(ev_o) > 15) ? 15 : m_cnt + int'(ev_o);
      end
      if (ev_o || ev_e) m_irq = 1'b1;
      else if (b8.irq_ack) m_irq = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("overflow", b8.overflow, m_ovf);
      check("zero", b8.zero, m_zero);
      check("negative", b8.negative, m_neg);
      check("error", b8.error, m_err);
      check("s_overflow", b8.s_overflow, m_sovf);
      check("s_error", b8.s_error, m_serr);
      check("ovf_count", b8.ovf_count, m_cnt);
      check("irq", b8.irq, m_irq);
      check("fsm_state", b8.fsm_state, m_irq);
      check("flags_valid", b8.flags_valid, m_fv);
    end
  end

  task automatic step(input bit v, input logic [2:0] op, input logic [7:0] res,
                      input bit c, input bit b, input bit m, input bit d,
                      input bit clr, input bit ack);
    b8.valid = v; b8.op = op; b8.result = res; b8.cout = c; b8.borrow = b;
    b8.mult_ovf = m; b8.div_error = d; b8.sticky_clr = clr; b8.irq_ack = ack;
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 3'd0, 8'd0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    b16.valid = 0; b16.op = 3'd2; b16.result = '0; b16.cout = 0; b16.borrow = 0;
    b16.mult_ovf = 0; b16.div_error = 0; b16.sticky_clr = 0; b16.irq_ack = 0;
    idle();
    idle();
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle();
    check("lit_reset_zero", b8.zero, 1'b0);
    check("lit_reset_irq", b8.irq, 1'b0);

    // ADD with carry
    step(1, 3'd0, 8'h2C, 1, 0, 0, 0, 0, 0);
    check("lit_add_ovf", {b8.overflow, b8.zero, b8.negative, b8.s_overflow, b8.irq, b8.flags_valid}, 6'b100111);
    check("lit_add_cnt", b8.ovf_count, 4'd1);
    idle();
    check("lit_fv_pulse", b8.flags_valid, 1'b0);
    // SUB borrow, then non-overflowing op with cout set
    step(1, 3'd1, 8'hFE, 0, 1, 0, 0, 0, 0);
    check("lit_sub", {b8.overflow, b8.negative}, 2'b11);
    step(1, 3'd2, 8'h00, 1, 0, 0, 0, 0, 0);
    check("lit_op2", {b8.overflow, b8.zero, b8.s_overflow}, 3'b011);
    // saturation, then clear colliding with an event
    for (int i = 0; i < 20; i++) step(1, 3'd5, 8'h11, 0, 0, 1, 0, 0, 0);
    check("lit_sat", b8.ovf_count, 4'd15);
    idle();
    check("lit_sat_hold", b8.ovf_count, 4'd15);
    step(1, 3'd5, 8'h11, 0, 0, 1, 0, 1, 0);
    check("lit_clr_evt", {b8.s_overflow, b8.ovf_count}, 5'b1_0001);
    // divide error and acknowledge handling
    step(0, 3'd0, 8'd0, 0, 0, 0, 0, 0, 1);
    check("lit_ack_idle", b8.irq, 1'b0);
    step(1, 3'd4, 8'h05, 0, 0, 0, 1, 0, 0);
    check("lit_div", {b8.error, b8.s_error, b8.irq}, 3'b111);
    step(0, 3'd0, 8'd0, 0, 0, 0, 0, 0, 1);
    check("lit_ack", b8.irq, 1'b0);
    step(1, 3'd0, 8'h01, 1, 0, 0, 0, 0, 0);
    step(1, 3'd0, 8'h01, 1, 0, 0, 0, 0, 1);
    check("lit_ack_evt", b8.irq, 1'b1);
    step(0, 3'd0, 8'd0, 0, 0, 0, 0, 1, 0);
    check("lit_clr_keeps_irq", b8.irq, 1'b1);
    // reset mid-alert overriding an event
    step(1, 3'd4, 8'h00, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b0;
    step(1, 3'd0, 8'h80, 1, 0, 0, 1, 1, 1);
    rst_n = 1'b1;
    check("lit_rst_all", {b8.overflow, b8.zero, b8.negative, b8.error, b8.s_overflow,
                          b8.s_error, b8.ovf_count, b8.irq, b8.flags_valid}, 13'd0);
    idle();
    idle();
    check("lit_rst_hold", {b8.overflow, b8.zero, b8.error}, 3'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    end
    rst_n = 1'b1;

    // 16-bit instance
    b16.valid = 1; b16.result = 16'h8000;
    @(negedge clk);
    check("w16_neg", {b16.negative, b16.zero}, 2'b10);
    b16.result = 16'h0000;
    @(negedge clk);
    check("w16_zero", {b16.negative, b16.zero}, 2'b01);
    b16.result = 16'h0100;
    @(negedge clk);
    check("w16_upper", {b16.negative, b16.zero}, 2'b00);
    b16.valid = 0;
    idle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/status_flags_unit.md
STATUS_FLAGS_UNIT -- requirements
Module: status_flags_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the ALU result width (legal range 4..32).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the overflow event counter width (legal range 2..16).
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: port clk, input, 1 bit, rising-edge clock; port rst_n, input, 1 bit, reset.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
  - valid, input, 1: a new ALU result is present this cycle.
  - result, input, WIDTH: ALU result.
  - cout, input, 1: adder carry out.
  - borrow, input, 1: subtractor borrow.
  - mult_ovf, input, 1: product does not fit in WIDTH bits.
  - div_error, input, 1: divide by zero.
  - op, input, 3: operation code.
  - sticky_clr, input, 1: clear sticky flags and counter.
  - irq_ack, input, 1: acknowledge the interrupt.
  - overflow, zero, negative, error, output, 1 each: registered live flags.
  - s_overflow, s_error, output, 1 each: sticky flags.
  - ovf_count, output, CNT_W: saturating overflow event count.
  - irq, output, 1: interrupt level.
  - flags_valid, output, 1: live flags updated last cycle.

Function
REQ-005 The block SHALL use these op decodes: ADD=000, SUB=001, MUL=101; all other codes SHALL produce no overflow.
REQ-006 The raw overflow SHALL be (ADD and cout) or (SUB and borrow) or (MUL and mult_ovf).
REQ-007 Raw zero SHALL be result==0 over all WIDTH bits; raw negative SHALL be result[WIDTH-1]; raw error SHALL be div_error, independent of op.
REQ-008 On a clock edge with valid=1, the block SHALL register the raw flags into overflow, zero, negative and error, giving 1-cycle latency.
REQ-009 On a clock edge with valid=0, the live flags SHALL hold their values.
REQ-010 flags_valid SHALL be a registered copy of valid, high for exactly one cycle per accepted result.
REQ-011 On a valid edge with raw overflow=1, s_overflow SHALL set; on a valid edge with raw error=1, s_error SHALL set; both SHALL remain set until sticky_clr or reset.
REQ-012 On a valid edge with raw overflow=1, ovf_count SHALL increment by 1 and saturate at 2^CNT_W-1 (no wrap).
REQ-013 sticky_clr=1 SHALL clear s_overflow, s_error and ovf_count at the next edge.
REQ-014 If sticky_clr=1 and valid=1 with an event occur in the same cycle, the clear SHALL win for the old contents and the new event SHALL be recorded: the sticky flag ends at 1 and ovf_count ends at 1.
REQ-015 The interrupt FSM SHALL have states IDLE and ALERT, and irq SHALL equal 1 exactly when the state is ALERT (registered output).
REQ-016 The FSM SHALL move from IDLE to ALERT on a valid edge with raw overflow or raw error.
REQ-017 The FSM SHALL move from ALERT to IDLE on irq_ack=1 with no new event in the same cycle.
REQ-018 If irq_ack and a new event occur in the same cycle, the FSM SHALL stay in ALERT.
REQ-019 irq_ack in IDLE SHALL be ignored.
REQ-020 sticky_clr SHALL NOT affect the FSM state.
REQ-021 Live flags, sticky flags and the counter SHALL update independently of the FSM state; no event is dropped while in ALERT.

Reset
REQ-022 While rst_n=0 at a clock edge, the block SHALL clear overflow, zero, negative, error, s_overflow, s_error, ovf_count and flags_valid to 0 and set the FSM to IDLE, so irq=0.
REQ-023 Reset SHALL override valid, sticky_clr and irq_ack in the same cycle.
REQ-024 A reset asserted mid-ALERT SHALL drop irq on the next edge.
REQ-025 The zero output SHALL read 0 after reset, not 1, until the first valid result.

Verification
REQ-026 WIDTH=8, valid with op=000, result=0x2C, cout=1 -> next cycle overflow=1, zero=0, negative=0, s_overflow=1, ovf_count=1, irq=1, flags_valid=1.
REQ-027 op=001, result=0xFE, borrow=1 -> overflow=1, negative=1. Then op=010 with cout=1 and result=0x00 -> overflow=0, zero=1, and s_overflow stays 1.
REQ-028 CNT_W=4, 20 consecutive MUL overflow results -> ovf_count=15 and held there. Then sticky_clr together with a MUL overflow -> ovf_count=1, s_overflow=1.
REQ-029 div_error=1 with op=100 -> error=1, s_error=1, irq=1. Then irq_ack alone -> irq=0 next cycle. Then irq_ack and an overflow result in the same cycle -> irq stays 1.
REQ-030 WIDTH=16, result=0x8000 -> negative=1, zero=0; result=0x0000 -> zero=1.
REQ-031 rst_n=0 while irq=1, s_error=1 and valid=1 with an event -> all outputs 0 after that edge. Valid held 0 afterwards -> live flags hold 0.
